hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 81 ++++++++
 tb/tb_hazard_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: register-dependency stalls plus mult/div busy tracking.
// Optional STALL_CNT_EN adds a saturating 32-bit StallCnt output.
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] A1D,
  input  logic [4:0] A2D,
  input  logic [1:0] TuseRsD,
  input  logic [1:0] TuseRtD,
  input  logic [4:0] A3E,
  input  logic [4:0] A3M,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic [1:0] TnewE,
  input  logic [1:0] TnewM,
  input  logic       MdStartE,
  input  logic       MdTypeE,
  input  logic       MdUseD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       BusyMD
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] StallCnt
`endif
);

  logic [3:0] r_md_cnt;
  logic       w_md_active;
  logic       w_stall_rs;
  logic       w_stall_rt;
  logic       w_stall_md;
  logic       w_stall;

  assign w_md_active = (r_md_cnt != '0);

  // A start while the counter is running is ignored; the countdown simply continues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (w_md_active) begin
      r_md_cnt <= r_md_cnt - 4'd1;
    end else if (MdStartE) begin
      r_md_cnt <= MdTypeE ? 4'd10 : 4'd5;
    end
  end

  always_comb begin
    w_stall_rs = (A1D != '0) &&
                 (((TuseRsD < TnewE) && RegWriteE && (A3E == A1D)) ||
                  ((TuseRsD < TnewM) && RegWriteM && (A3M == A1D)));
    w_stall_rt = (A2D != '0) &&
                 (((TuseRtD < TnewE) && RegWriteE && (A3E == A2D)) ||
                  ((TuseRtD < TnewM) && RegWriteM && (A3M == A2D)));
  end

  // Reset masks every output so nothing downstream sees a stall or busy while held.
  assign BusyMD     = ~reset & (MdStartE | w_md_active);
  assign w_stall_md = MdUseD & BusyMD;
  assign w_stall    = ~reset & (w_stall_rs | w_stall_rt | w_stall_md);

  assign StallF = w_stall;
  assign StallD = w_stall;
  assign FlushE = w_stall;

`ifdef STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign StallCnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-number based reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] A1D, A2D, A3E, A3M;
  logic [1:0] TuseRsD, TuseRtD, TnewE, TnewM;
  logic       RegWriteE, RegWriteM, MdStartE, MdTypeE, MdUseD;
  logic       StallF, StallD, FlushE, BusyMD;
`ifdef STALL_CNT_EN
  logic [31:0] StallCnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .A1D(A1D), .A2D(A2D), .TuseRsD(TuseRsD), .TuseRtD(TuseRtD),
    .A3E(A3E), .A3M(A3M), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .TnewE(TnewE), .TnewM(TnewM), .MdStartE(MdStartE), .MdTypeE(MdTypeE),
    .MdUseD(MdUseD), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .BusyMD(BusyMD)
`ifdef STALL_CNT_EN
    , .StallCnt(StallCnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: mult/div occupancy expressed as "busy until cycle number".
  longint cyc        = 0;
  longint busy_until = 0;
  longint m_stallcnt = 0;

  function automatic bit dep(input logic [4:0] a, input logic [1:0] tuse);
    bit e_hit, m_hit;
    e_hit = RegWriteE && (A3E == a) && (int'(tuse) < int'(TnewE));
    m_hit = RegWriteM && (A3M == a) && (int'(tuse) < int'(TnewM));
    return (a != 5'd0) && (e_hit || m_hit);
  endfunction

  function automatic bit m_busy();
    return !reset && (MdStartE || (cyc < busy_until));
  endfunction

  function automatic bit m_stall();
    return !reset && (dep(A1D, TuseRsD) || dep(A2D, TuseRtD) || (MdUseD && m_busy()));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_until = 0;
      m_stallcnt = 0;
    end else begin
      if (m_stall() && m_stallcnt < 64'hFFFF_FFFF) m_stallcnt = m_stallcnt + 1;
      cyc = cyc + 1;
      if (MdStartE && !(cyc - 1 < busy_until))
        busy_until = cyc + (MdTypeE ? 10 : 5);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    A1D = '0; A2D = '0; A3E = '0; A3M = '0;
    TuseRsD = 2'd3; TuseRtD = 2'd3; TnewE = '0; TnewM = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0;
    MdStartE = 1'b0; MdTypeE = 1'b0; MdUseD = 1'b0;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check({tag, ".F"}, {31'd0, StallF}, {31'd0, exp});
    check({tag, ".D"}, {31'd0, StallD}, {31'd0, exp});
    check({tag, ".E"}, {31'd0, FlushE}, {31'd0, exp});
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1;
    check_stall("rst_stall", 1'b0);
    check("rst_busy", {31'd0, BusyMD}, 32'd0);
    MdStartE = 1'b1; MdUseD = 1'b1;
    #1;
    check("rst_gate_busy", {31'd0, BusyMD}, 32'd0);
    check_stall("rst_gate_stall", 1'b0);
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Load-use against E stage, then same vector with register 0.
    @(negedge clk);
    A1D = 5'd5; TuseRsD = 2'd0; A3E = 5'd5; RegWriteE = 1'b1; TnewE = 2'd2;
    #1 check_stall("loaduse", 1'b1);
    A1D = 5'd0; A3E = 5'd0;
    #1 check_stall("loaduse_r0", 1'b0);

    // M-stage hazard on rt.
    idle();
    A2D = 5'd7; TuseRtD = 2'd0; A3M = 5'd7; RegWriteM = 1'b1; TnewM = 2'd1;
    #1 check_stall("mhaz", 1'b1);
    TuseRtD = 2'd1;
    #1 check_stall("mhaz_tuse1", 1'b0);

    // Div: stall for 10 cycles after the issuing edge, free on the 11th.
    idle();
    MdStartE = 1'b1; MdTypeE = 1'b1;
    @(negedge clk);
    MdStartE = 1'b0; MdUseD = 1'b1;
    for (int i = 0; i < 11; i++) begin
      #1 check($sformatf("div_c%0d", i + 1), {31'd0, StallF}, {31'd0, (i < 10)});
      @(negedge clk);
    end

    // Mult with a re-issue while the count sits at 3.
    idle();
    MdStartE = 1'b1;
    @(negedge clk);
    MdStartE = 1'b0;
    #1 check("mult_c1", {31'd0, BusyMD}, 32'd1);
    repeat (2) @(negedge clk);
    MdStartE = 1'b1;
    @(negedge clk);
    MdStartE = 1'b0;
    #1 check("reissue_2", {31'd0, BusyMD}, 32'd1);
    @(negedge clk);
    #1 check("reissue_1", {31'd0, BusyMD}, 32'd1);
    @(negedge clk);
    #1 check("reissue_0", {31'd0, BusyMD}, 32'd0);

    // Mult issued at edge N: busy through five following cycles, idle on the sixth.
    idle();
    MdStartE = 1'b1;
    @(negedge clk);
    MdStartE = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 check($sformatf("mult_len%0d", i + 1), {31'd0, BusyMD}, {31'd0, (i < 5)});
      @(negedge clk);
    end

    // Reset mid-mult, off the clock edge.
    MdStartE = 1'b1;
    @(negedge clk);
    MdStartE = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("rstmid_busy", {31'd0, BusyMD}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    MdUseD = 1'b1;
    #1 check_stall("rstmid_nostall", 1'b0);
    check("rstmid_busy_after", {31'd0, BusyMD}, 32'd0);
    repeat (7) begin
      @(negedge clk);
      #1 check("rstmid_stays_idle", {31'd0, BusyMD}, 32'd0);
    end

`ifdef STALL_CNT_EN
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    A1D = 5'd5; TuseRsD = 2'd0; A3E = 5'd5; RegWriteE = 1'b1; TnewE = 2'd2;
    repeat (4) @(negedge clk);
    idle();
    @(negedge clk);
    check("stallcnt_4", StallCnt, 32'd4);
    #2 reset = 1'b1;
    #1 check("stallcnt_rst", StallCnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
`endif

    // Randomized traffic vs the reference model; small register indices to force collisions.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      A1D = 5'($urandom_range(0, 3)); A2D = 5'($urandom_range(0, 3));
      A3E = 5'($urandom_range(0, 3)); A3M = 5'($urandom_range(0, 3));
      TuseRsD = 2'($urandom); TuseRtD = 2'($urandom);
      TnewE = 2'($urandom); TnewM = 2'($urandom);
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom);
      MdStartE = ($urandom_range(0, 9) == 0);
      MdTypeE = 1'($urandom);
      MdUseD = 1'($urandom);
      reset = ($urandom_range(0, 59) == 0);
      #1;
      check("rnd_stallF", {31'd0, StallF}, {31'd0, m_stall()});
      check("rnd_stallD", {31'd0, StallD}, {31'd0, m_stall()});
      check("rnd_flushE", {31'd0, FlushE}, {31'd0, m_stall()});
      check("rnd_busy", {31'd0, BusyMD}, {31'd0, m_busy()});
`ifdef STALL_CNT_EN
      check("rnd_stallcnt", StallCnt, 32'(m_stallcnt));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
